alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  upstream command present.
REQ-005 SHALL have port cmd_ready  output  1  block can accept a command this cycle.
REQ-006 SHALL have port cmd_a  input  16  operand to drive onto alu16 i0.
REQ-007 SHALL have port cmd_b  input  16  operand to drive onto alu16 i1.
REQ-008 SHALL have port cmd_op  input  2  opcode to drive onto alu16 op.
REQ-009 SHALL have port alu_i0  output  16  registered operand to alu16 i0.
REQ-010 SHALL have port alu_i1  output  16  registered operand to alu16 i1.
REQ-011 SHALL have port alu_op  output  2  registered opcode to alu16 op.
REQ-012 SHALL have port alu_y  input  16  combinational alu16 result.
REQ-013 SHALL have port alu_cout  input  1  combinational alu16 carry-out.
REQ-014 SHALL have port res_valid  output  1  captured result available.
REQ-015 SHALL have port res_ready  input  1  downstream accepts result.
REQ-016 SHALL have port res_data  output  16  captured alu_y.
REQ-017 SHALL have port res_cout  output  1  captured alu_cout.
REQ-018 SHALL have port ops_done  output  8  count of completed result handshakes.

Function
REQ-019 SHALL push a command into the FIFO on any rising edge with cmd_valid && cmd_ready.
REQ-020 SHALL drive cmd_ready = (count < DEPTH), from registered count only; no same-cycle pop bypass when full.
REQ-021 SHALL keep count unchanged on simultaneous push and pop; pointers wrap modulo DEPTH.
REQ-022 SHALL implement FSM states IDLE, EXEC, WAIT.
REQ-023 IDLE: if FIFO non-empty, SHALL load head into alu_i0/alu_i1/alu_op, pop, go EXEC; else stay IDLE.
REQ-024 EXEC: SHALL capture alu_y/alu_cout into res_data/res_cout, set res_valid=1, go WAIT; exactly one cycle.
REQ-025 WAIT: SHALL hold res_valid, res_data, res_cout and alu_* stable while res_ready=0.
REQ-026 WAIT with res_ready=1: SHALL clear res_valid, increment ops_done (8-bit, 255 wraps to 0); if FIFO non-empty, load/pop next head and go EXEC, else go IDLE.
REQ-027 SHALL give latency 2 cycles from accept edge (empty FIFO, IDLE) to res_valid high; steady-state throughput one result per 2 cycles with res_ready held 1.
REQ-028 SHALL retain alu_i0/alu_i1/alu_op values after pop until next load.
REQ-029 SHALL never drop, duplicate or reorder commands; results emerge in acceptance order.
REQ-030 SHALL ignore cmd_a/cmd_b/cmd_op when cmd_valid=0, and res_ready outside WAIT.

Reset
REQ-031 On rising edge with rst_n=0 SHALL set state IDLE, FIFO empty, count 0, alu_i0=0, alu_i1=0, alu_op=0, res_valid=0, res_data=0, res_cout=0, ops_done=0.
REQ-032 Reset mid-operation SHALL discard queued commands and any pending result; cmd_ready=1 on first cycle after release.
REQ-033 SHALL accept no command on an edge where rst_n=0.

Verification
REQ-034 Single op: push a=F0F0, b=0FF0, op=00 at edge N, res_ready=1 -> alu_i0=F0F0/alu_i1=0FF0/alu_op=00 after N+1, res_valid=1 with res_data=alu16 result after N+2, ops_done=1 after N+3.
REQ-035 Back-pressure: res_ready=0, cmd_valid=1 continuously -> exactly DEPTH+1 (5) commands accepted then cmd_ready=0; res_data stable throughout.
REQ-036 Ordering: push ops 00,01,10,11 on same operands, res_ready=1 -> four results in op order 00..11, each matching alu16 model incl. res_cout.
REQ-037 Simultaneous push/pop at count=2 -> count stays 2, no entry lost.
REQ-038 Reset mid-WAIT with 3 queued -> all outputs zero, cmd_ready=1, no further res_valid until new command.
REQ-039 Counter wrap: 256 completed handshakes -> ops_done returns to 0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Queues 16-bit ALU commands in a small FIFO, issues them one at a time
//   onto registered alu16 operand/opcode lines, captures the combinational
//   alu16 result one cycle later, and holds it until the downstream side
//   takes it. Completed result handshakes are counted modulo 256.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   synchronous active-low reset
//   cmd_valid  in   upstream command present
//   cmd_ready  out  FIFO has room (from registered occupancy only)
//   cmd_a      in   [15:0] operand for alu16 i0
//   cmd_b      in   [15:0] operand for alu16 i1
//   cmd_op     in   [1:0]  opcode for alu16 op
//   alu_i0     out  [15:0] registered operand to alu16 i0
//   alu_i1     out  [15:0] registered operand to alu16 i1
//   alu_op     out  [1:0]  registered opcode to alu16 op
//   alu_y      in   [15:0] combinational alu16 result
//   alu_cout   in   combinational alu16 carry-out
//   res_valid  out  captured result available
//   res_ready  in   downstream accepts result
//   res_data   out  [15:0] captured alu_y
//   res_cout   out  captured alu_cout
//   ops_done   out  [7:0]  completed result handshakes, wraps at 256
module alu_issue_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [1:0]  cmd_op,
    output logic [15:0] alu_i0,
    output logic [15:0] alu_i1,
    output logic [1:0]  alu_op,
    input  logic [15:0] alu_y,
    input  logic        alu_cout,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_cout,
    output logic [7:0]  ops_done
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
    } cmd_t;

    state_t          state_q, state_d;
    cmd_t            mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     alu_i0_q, alu_i0_d;
    logic [15:0]     alu_i1_q, alu_i1_d;
    logic [1:0]      alu_op_q, alu_op_d;
    logic            res_valid_q, res_valid_d;
    logic [15:0]     res_data_q, res_data_d;
    logic            res_cout_q, res_cout_d;
    logic [7:0]      ops_done_q, ops_done_d;
    logic            push_s;
    logic            pop_s;
    logic            fifo_ne_s;
    cmd_t            head_s;

    // Ready depends only on registered occupancy: a pop on the same edge
    // never frees a slot for a push while full.
    assign cmd_ready = (count_q < CW'(DEPTH));
    assign fifo_ne_s = (count_q != '0);
    assign head_s    = mem_q[rd_ptr_q];

    assign alu_i0    = alu_i0_q;
    assign alu_i1    = alu_i1_q;
    assign alu_op    = alu_op_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_cout  = res_cout_q;
    assign ops_done  = ops_done_q;

    // Next-state, issue and result-capture logic.
    always_comb begin
        state_d     = state_q;
        alu_i0_d    = alu_i0_q;
        alu_i1_d    = alu_i1_q;
        alu_op_d    = alu_op_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_cout_d  = res_cout_q;
        ops_done_d  = ops_done_q;
        pop_s       = 1'b0;
        push_s      = cmd_valid && cmd_ready;

        case (state_q)
            ST_IDLE: begin
                if (fifo_ne_s) begin
                    pop_s   = 1'b1;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                res_data_d  = alu_y;
                res_cout_d  = alu_cout;
                res_valid_d = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    ops_done_d  = ops_done_q + 8'd1;
                    if (fifo_ne_s) begin
                        pop_s   = 1'b1;
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        // Operands stay on the ALU lines until the next load.
        if (pop_s) begin
            alu_i0_d = head_s.a;
            alu_i1_d = head_s.b;
            alu_op_d = head_s.op;
        end else begin
            alu_i0_d = alu_i0_d;
        end
    end

    // FIFO pointer and occupancy update; pointers wrap as DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State, datapath and FIFO registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_i0_q    <= 16'd0;
            alu_i1_q    <= 16'd0;
            alu_op_q    <= 2'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= 16'd0;
            res_cout_q  <= 1'b0;
            ops_done_q  <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            alu_i0_q    <= alu_i0_d;
            alu_i1_q    <= alu_i1_d;
            alu_op_q    <= alu_op_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_cout_q  <= res_cout_d;
            ops_done_q  <= ops_done_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a queue-based reference model
// plus an alu16 stand-in, with directed scenarios and a random phase.
module tb_alu_issue_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_a = 16'd0;
    logic [15:0] cmd_b = 16'd0;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] alu_i0, alu_i1;
    logic [1:0]  alu_op;
    logic [15:0] alu_y;
    logic        alu_cout;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_cout;
    logic [7:0]  ops_done;

    int checks = 0;
    int failures = 0;
    int acc_cnt = 0;
    int hs_cnt = 0;
    logic [16:0] got [4];

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
    } cmd_t;

    // alu16 stand-in: add, subtract (cout = no borrow), and, xor
    function automatic logic [16:0] alu16(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} + {1'b0, ~b} + 17'd1;
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    assign {alu_cout, alu_y} = alu16(alu_i0, alu_i1, alu_op);

    alu_issue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_i0(alu_i0), .alu_i1(alu_i1), .alu_op(alu_op),
        .alu_y(alu_y), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_cout(res_cout),
        .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: pending-command queue, at most one command at the ALU,
    // and an expected-result queue in acceptance order.
    cmd_t        mq[$];
    logic [16:0] eq[$];
    logic        m_busy = 1'b0, m_rv = 1'b0, m_cout = 1'b0;
    logic [15:0] m_a = 16'd0, m_b = 16'd0, m_data = 16'd0;
    logic [1:0]  m_op = 2'd0;
    logic [7:0]  m_done = 8'd0;
    logic        m_push, m_load;
    cmd_t        m_cmd, m_in;

    always begin : ref_model
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mq.delete();
            eq.delete();
            m_busy = 1'b0; m_rv = 1'b0; m_cout = 1'b0;
            m_a = 16'd0; m_b = 16'd0; m_op = 2'd0; m_data = 16'd0; m_done = 8'd0;
        end else begin
            m_push = cmd_valid && (mq.size() < DEPTH);
            m_load = 1'b0;
            if (!m_busy) begin
                m_load = (mq.size() > 0);
            end else if (!m_rv) begin
                {m_cout, m_data} = alu16(m_a, m_b, m_op);
                m_rv = 1'b1;
            end else if (res_ready) begin
                m_rv = 1'b0;
                m_busy = 1'b0;
                m_done = m_done + 8'd1;
                void'(eq.pop_front());
                m_load = (mq.size() > 0);
            end
            if (m_load) begin
                m_cmd = mq.pop_front();
                m_a = m_cmd.a; m_b = m_cmd.b; m_op = m_cmd.op;
                m_busy = 1'b1;
            end
            if (m_push) begin
                m_in = {cmd_a, cmd_b, cmd_op};
                mq.push_back(m_in);
                eq.push_back(alu16(cmd_a, cmd_b, cmd_op));
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
        chk("alu_i0", alu_i0, m_a);
        chk("alu_i1", alu_i1, m_b);
        chk("alu_op", alu_op, m_op);
        chk("res_valid", res_valid, m_rv);
        chk("res_data", res_data, m_data);
        chk("res_cout", res_cout, m_cout);
        chk("ops_done", ops_done, m_done);
        if (res_valid === 1'b1) begin
            chk("order_avail", eq.size() > 0, 1);
            if (eq.size() > 0) chk("order_result", {res_cout, res_data}, eq[0]);
        end
    end

    task automatic tick();
        if (rst_n && cmd_valid && cmd_ready) acc_cnt++;
        if (rst_n && res_valid && res_ready) begin
            if (hs_cnt < 4) got[hs_cnt] = {res_cout, res_data};
            hs_cnt++;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        acc_cnt = 0;
        hs_cnt = 0;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
        tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_alu_i0"}, alu_i0, 16'd0);
        chk({tag, "_alu_op"}, alu_op, 2'd0);
        chk({tag, "_res_valid"}, res_valid, 1'b0);
        chk({tag, "_res_data"}, res_data, 16'd0);
        chk({tag, "_ops_done"}, ops_done, 8'd0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk_zero("reset");

        // Single op: accept at edge N, operands after N+1, result after N+2
        res_ready = 1'b1;
        push(16'hF0F0, 16'h0FF0, 2'b00);
        cmd_valid = 1'b0;
        tick();
        chk("single_i0", alu_i0, 16'hF0F0);
        chk("single_i1", alu_i1, 16'h0FF0);
        chk("single_valid_early", res_valid, 1'b0);
        tick();
        chk("single_valid", res_valid, 1'b1);
        chk("single_data", res_data, 16'h00E0);
        chk("single_cout", res_cout, 1'b1);
        tick();
        chk("single_done", ops_done, 8'd1);

        // Ordering over all four opcodes
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(16'h8001, 16'h8003, 2'(i));
        cmd_valid = 1'b0;
        for (int i = 0; i < 40 && hs_cnt < 4; i++) tick();
        chk("order_count", hs_cnt, 4);
        chk("order_add", got[0], 17'h10004);
        chk("order_sub", got[1], 17'h0FFFE);
        chk("order_and", got[2], 17'h08001);
        chk("order_xor", got[3], 17'h00002);

        // Back-pressure: DEPTH queued plus one at the ALU
        do_reset();
        push(16'h1234, 16'h1111, 2'b00);
        for (int i = 0; i < 10; i++) push(16'($urandom), 16'($urandom), 2'($urandom));
        chk("bp_accepted", acc_cnt, DEPTH + 1);
        chk("bp_cmd_ready", cmd_ready, 1'b0);
        chk("bp_res_data", res_data, 16'h2345);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 40 && hs_cnt < 5; i++) tick();
        chk("bp_drained", hs_cnt, 5);

        // Simultaneous push and pop at count=2
        do_reset();
        for (int i = 0; i < 3; i++) push(16'(i + 7), 16'h0003, 2'b01);
        res_ready = 1'b1;
        push(16'h00AA, 16'h0055, 2'b11);
        chk("pp_cmd_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 40 && hs_cnt < 4; i++) tick();
        chk("pp_all_results", hs_cnt, 4);

        // Reset mid-WAIT with three queued
        do_reset();
        for (int i = 0; i < 4; i++) push(16'(i + 100), 16'h0101, 2'b10);
        cmd_valid = 1'b0;
        chk("rw_in_wait", res_valid, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_zero("rw");
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rw_no_result", res_valid, 1'b0);
        end

        // ops_done wraps after 256 handshakes
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 3000 && hs_cnt < 256; i++) push(16'($urandom), 16'($urandom), 2'($urandom));
        cmd_valid = 1'b0;
        chk("wrap_hs", hs_cnt, 256);
        chk("wrap_ops_done", ops_done, 8'd0);

        // Random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 800; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            cmd_valid = ($urandom_range(0, 1) == 1);
            res_ready = ($urandom_range(0, 3) != 0);
            cmd_a     = 16'($urandom);
            cmd_b     = 16'($urandom);
            cmd_op    = 2'($urandom);
            tick();
        end
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
